// File: rtl/cpu_pkg.sv
// Shared decode definitions for the issue stage and the ALU: function codes,
// instruction field positions, and the legality / operand-usage helpers.
package cpu_pkg;
    localparam int NREGS = 16;
    localparam int RW    = 4;

    localparam int FN_HI  = 31;
    localparam int FN_LO  = 26;
    localparam int IMMSEL = 25;
    localparam int RD_HI  = 24;
    localparam int RD_LO  = 21;
    localparam int RS_HI  = 20;
    localparam int RS_LO  = 17;
    localparam int RT_HI  = 16;
    localparam int RT_LO  = 13;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [5:0] {
        OP_ADD  = 6'h00, OP_SUB  = 6'h01, OP_AND  = 6'h04, OP_OR   = 6'h05,
        OP_XOR  = 6'h06, OP_MVHI = 6'h0B, OP_SLL  = 6'h0C, OP_SRL  = 6'h0D,
        OP_SRA  = 6'h0E, OP_F    = 6'h10, OP_EQ   = 6'h11, OP_LT   = 6'h12,
        OP_LE   = 6'h13, OP_NE   = 6'h15, OP_GE   = 6'h16, OP_GT   = 6'h17,
        OP_T    = 6'h18, OP_LTU  = 6'h19, OP_LEU  = 6'h1A, OP_GEU  = 6'h1B,
        OP_GTU  = 6'h1D, OP_NEU  = 6'h1E, OP_EQU  = 6'h1F, OP_JAL  = 6'h20
    } opsel_e;

    typedef struct packed {
        logic [5:0]    fn;
        logic          imm_sel;
        logic [RW-1:0] rd;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [15:0]   imm16;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d.fn      = w[FN_HI:FN_LO];
        d.imm_sel = w[IMMSEL];
        d.rd      = w[RD_HI:RD_LO];
        d.rs      = w[RS_HI:RS_LO];
        d.rt      = w[RT_HI:RT_LO];
        d.imm16   = w[IMM_HI:IMM_LO];
        return d;
    endfunction

    function automatic logic fn_legal(input logic [5:0] fn);
        case (fn)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MVHI, OP_SLL, OP_SRL,
            OP_SRA, OP_F, OP_EQ, OP_LT, OP_LE, OP_NE, OP_GE, OP_GT, OP_T,
            OP_LTU, OP_LEU, OP_GEU, OP_GTU, OP_NEU, OP_EQU, OP_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Illegal codes read nothing so they can never stall.
    function automatic logic uses_rs(input logic [5:0] fn);
        return fn_legal(fn) && !(fn inside {OP_MVHI, OP_F, OP_T, OP_JAL});
    endfunction

    function automatic logic uses_rt(input logic [5:0] fn, input logic imm_sel);
        return uses_rs(fn) && !imm_sel;
    endfunction
endpackage

// File: rtl/regfile.sv
// 16x32 register file: two read ports, one synchronous write port,
// reset-clear, r0 hardwired to zero, same-cycle write-through to readers.
module regfile
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [RW-1:0] ra,
    input  logic [RW-1:0] rb,
    output logic [31:0]   rdata_a,
    output logic [31:0]   rdata_b,
    input  logic          we,
    input  logic [RW-1:0] wa,
    input  logic [31:0]   wdata
);
    logic [NREGS-1:0][31:0] mem;

    always_ff @(posedge clk) begin
        if (reset)
            mem <= '0;
        else if (we && wa != '0)
            mem[wa] <= wdata;
    end

    always_comb begin
        rdata_a = mem[ra];
        rdata_b = mem[rb];
        if (we && wa == ra) rdata_a = wdata;
        if (we && wa == rb) rdata_b = wdata;
        if (ra == '0) rdata_a = '0;
        if (rb == '0) rdata_b = '0;
    end
endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue stage feeding the ALU: register read with writeback bypass,
// operand selection, and a per-register busy scoreboard for RAW/WAW interlock.
module alu_issue
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [31:0]   in_pc,
    input  logic          wb_en,
    input  logic [RW-1:0] wb_rd,
    input  logic [31:0]   wb_data,
    output logic [5:0]    opsel,
    output logic [31:0]   A,
    output logic [31:0]   B,
    output logic          out_valid,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic          err
);
    localparam int STAGES = 1;

    dec_t             d;
    logic             legal, need_rs, need_rt, writes, accept;
    logic [NREGS-1:0] busy, wb_clr, busy_eff, busy_set;
    logic [31:0]      rs_val, rt_val, imm32, a_nxt, b_nxt;
    logic [STAGES:0]  vld_pipe;

    assign d       = decode(in_instr);
    assign legal   = fn_legal(d.fn);
    assign need_rs = uses_rs(d.fn);
    assign need_rt = uses_rt(d.fn, d.imm_sel);
    assign writes  = legal && d.fn != OP_JAL && d.rd != '0;
    assign imm32   = {{16{d.imm16[15]}}, d.imm16};

    // A writeback landing this cycle releases its register for the reader.
    always_comb begin
        wb_clr = '0;
        if (wb_en && wb_rd != '0) wb_clr[wb_rd] = 1'b1;
    end
    assign busy_eff = busy & ~wb_clr;

    assign in_ready = !reset
                   && !(need_rs && busy_eff[d.rs])
                   && !(need_rt && busy_eff[d.rt])
                   && !(writes  && busy_eff[d.rd]);
    assign accept   = in_valid && in_ready;

    regfile u_rf (
        .clk     (clk),
        .reset   (reset),
        .ra      (d.rs),
        .rb      (d.rt),
        .rdata_a (rs_val),
        .rdata_b (rt_val),
        .we      (wb_en),
        .wa      (wb_rd),
        .wdata   (wb_data)
    );

    always_comb begin
        a_nxt = rs_val;
        b_nxt = d.imm_sel ? imm32 : rt_val;
        case (d.fn)
            OP_MVHI: begin a_nxt = '0;    b_nxt = {16'b0, d.imm16}; end
            OP_F,
            OP_T:    begin a_nxt = '0;    b_nxt = '0;               end
            OP_JAL:  begin a_nxt = in_pc; b_nxt = imm32;            end
            default: ;
        endcase
    end

    always_comb begin
        busy_set = '0;
        if (accept && writes) busy_set[d.rd] = 1'b1;
    end

    assign vld_pipe[0] = accept && legal;
    assign out_valid   = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= '0;
            opsel       <= OP_ADD;
            A           <= '0;
            B           <= '0;
            out_rd      <= '0;
            out_we      <= 1'b0;
            err         <= 1'b0;
            vld_pipe[1] <= 1'b0;
        end else begin
            // Set is OR'd after the clear so a same-cycle re-issue keeps busy.
            busy        <= (busy & ~wb_clr) | busy_set;
            err         <= accept && !legal;
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                opsel  <= d.fn;
                A      <= a_nxt;
                B      <= b_nxt;
                out_rd <= d.rd;
                out_we <= writes;
            end
        end
    end
endmodule
